// File: rtl/hazard_if.sv
// Hazard controller bus: pipeline-stage facts in, stall/flush controls out.
// The pipeline drives through master; the hazard controller sits on slave.
interface hazard_if #(
    parameter int STAT_W = 16
);
    logic [4:0]        RSReg_ID;
    logic [4:0]        RTReg_ID;
    logic              UsesRT_ID;
    logic              Branch_ID;
    logic              Jr_ID;
    logic              Jump_ID;
    logic              BranchTaken_ID;
    logic              MulDivStart_ID;
    logic              MulDivUse_ID;
    logic [4:0]        RDReg_EX;
    logic              RegWrite_EX;
    logic              MemRead_EX;
    logic [4:0]        RDReg_M;
    logic              MemRead_M;
    logic              PCWrite;
    logic              IFIDWrite;
    logic              IDEXBubble;
    logic              IFIDFlush;
    logic              MulDivBusy;
    logic [STAT_W-1:0] StallCycles;

    modport master (
        output RSReg_ID, RTReg_ID, UsesRT_ID, Branch_ID, Jr_ID, Jump_ID,
               BranchTaken_ID, MulDivStart_ID, MulDivUse_ID,
               RDReg_EX, RegWrite_EX, MemRead_EX, RDReg_M, MemRead_M,
        input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, MulDivBusy, StallCycles
    );

    modport slave (
        input  RSReg_ID, RTReg_ID, UsesRT_ID, Branch_ID, Jr_ID, Jump_ID,
               BranchTaken_ID, MulDivStart_ID, MulDivUse_ID,
               RDReg_EX, RegWrite_EX, MemRead_EX, RDReg_M, MemRead_M,
        output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, MulDivBusy, StallCycles
    );
endinterface

// File: rtl/hazard_controller.sv
// Five-stage MIPS hazard sequencer: load-use, branch-in-ID operand and
// mul/div occupancy stalls, plus IF/ID flush on control transfer.
// Optional macro HAZARD_STATS_EN builds a saturating stalled-cycle counter;
// without it StallCycles is tied to zero.
module hazard_controller #(
    parameter int MULDIV_CYCLES = 32,
    parameter int STAT_W        = 16
) (
    input  logic     Clk,
    input  logic     Rst_n,
    hazard_if.slave  hz
);
    localparam int            CW      = $clog2(MULDIV_CYCLES + 1);
    localparam logic [CW-1:0] MD_LOAD = CW'(MULDIV_CYCLES);

    logic [CW-1:0] count;
    logic          busy;
    logic          lu, br_ex, br_m, md, stall;

    // Register zero is never a real producer, so it never creates a dependence.
    function automatic logic hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    assign busy = (count != '0);

    // Hazard terms; everything is masked while reset is asserted so the
    // pipeline free-runs out of reset.
    always_comb begin
        lu    = hz.MemRead_EX &
                (hit(hz.RDReg_EX, hz.RSReg_ID) |
                 (hz.UsesRT_ID & hit(hz.RDReg_EX, hz.RTReg_ID)));
        br_ex = (hz.Branch_ID | hz.Jr_ID) & hz.RegWrite_EX &
                (hit(hz.RDReg_EX, hz.RSReg_ID) |
                 (hz.Branch_ID & hit(hz.RDReg_EX, hz.RTReg_ID)));
        br_m  = (hz.Branch_ID | hz.Jr_ID) & hz.MemRead_M &
                (hit(hz.RDReg_M, hz.RSReg_ID) |
                 (hz.Branch_ID & hit(hz.RDReg_M, hz.RTReg_ID)));
        md    = busy & (hz.MulDivUse_ID | hz.MulDivStart_ID);
        stall = Rst_n & (lu | br_ex | br_m | md);
    end

    assign hz.PCWrite    = ~stall;
    assign hz.IFIDWrite  = ~stall;
    assign hz.IDEXBubble = stall;
    // A stalled branch stays in ID, so its flush waits until it is released.
    assign hz.IFIDFlush  = Rst_n & ~stall &
                           (hz.BranchTaken_ID | hz.Jump_ID | hz.Jr_ID);
    assign hz.MulDivBusy = busy;

    // Mul/div occupancy countdown; a start while busy is held off by md,
    // so a reload can only happen from zero.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            count <= '0;
        else if (hz.MulDivStart_ID && !stall)
            count <= MD_LOAD;
        else if (busy)
            count <= count - 1'b1;
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stat_cnt;

    // Stalled-cycle counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            stat_cnt <= '0;
        else if (stall && (stat_cnt != '1))
            stat_cnt <= stat_cnt + 1'b1;
    end

    assign hz.StallCycles = stat_cnt;
`else
    assign hz.StallCycles = '0;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller (MULDIV_CYCLES=4, STAT_W=4).
module tb_hazard_controller;
    localparam int N    = 4;
    localparam int SW   = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic Clk;
    logic Rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    hazard_if #(.STAT_W(SW)) hz ();

    hazard_controller #(.MULDIV_CYCLES(N), .STAT_W(SW)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .hz    (hz)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Reference model: mul/div occupancy kept as an absolute cycle window
    // (busy while edge count <= busy_end) plus a plain stall tally.
    int cyc      = 0;
    int busy_end = -1;
    int stat_m   = 0;

    function automatic bit m_hit(input logic [4:0] d, input logic [4:0] s);
        return (d != 0) && (d == s);
    endfunction

    function automatic bit model_busy();
        return (Rst_n === 1'b1) && (cyc <= busy_end);
    endfunction

    function automatic bit model_stall();
        bit reads_rt, lu, bx, bm, md;
        if (Rst_n !== 1'b1) return 1'b0;
        reads_rt = hz.Branch_ID;
        lu = hz.MemRead_EX && (m_hit(hz.RDReg_EX, hz.RSReg_ID) ||
                               (hz.UsesRT_ID && m_hit(hz.RDReg_EX, hz.RTReg_ID)));
        bx = (hz.Branch_ID || hz.Jr_ID) && hz.RegWrite_EX &&
             (m_hit(hz.RDReg_EX, hz.RSReg_ID) || (reads_rt && m_hit(hz.RDReg_EX, hz.RTReg_ID)));
        bm = (hz.Branch_ID || hz.Jr_ID) && hz.MemRead_M &&
             (m_hit(hz.RDReg_M, hz.RSReg_ID) || (reads_rt && m_hit(hz.RDReg_M, hz.RTReg_ID)));
        md = model_busy() && (hz.MulDivUse_ID || hz.MulDivStart_ID);
        return lu || bx || bm || md;
    endfunction

    always @(posedge Clk or negedge Rst_n) begin
        if (Rst_n !== 1'b1) begin
            cyc      <= 0;
            busy_end <= -1;
            stat_m   <= 0;
        end else begin
            if (model_stall() && stat_m < SMAX) stat_m <= stat_m + 1;
            if (hz.MulDivStart_ID && !model_stall()) busy_end <= cyc + N;
            cyc <= cyc + 1;
        end
    end

    // Observed control vector: {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, MulDivBusy}
    function automatic logic [4:0] obs();
        return {hz.PCWrite, hz.IFIDWrite, hz.IDEXBubble, hz.IFIDFlush, hz.MulDivBusy};
    endfunction

    function automatic logic [4:0] ev(input bit s, input bit f, input bit b);
        return {~s, ~s, s, f, b};
    endfunction

    task automatic idle();
        hz.RSReg_ID = 0; hz.RTReg_ID = 0; hz.UsesRT_ID = 0;
        hz.Branch_ID = 0; hz.Jr_ID = 0; hz.Jump_ID = 0; hz.BranchTaken_ID = 0;
        hz.MulDivStart_ID = 0; hz.MulDivUse_ID = 0;
        hz.RDReg_EX = 0; hz.RegWrite_EX = 0; hz.MemRead_EX = 0;
        hz.RDReg_M = 0; hz.MemRead_M = 0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] e;
        idle();
        Rst_n = 1'b0;
        hz.MemRead_EX = 1; hz.RDReg_EX = 8; hz.RSReg_ID = 8;
        hz.Jump_ID = 1; hz.MulDivUse_ID = 1; hz.MulDivStart_ID = 1;
        #2;
        e = ev(0, 0, 0);
        n_checks++;
        if (obs() !== e) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want %b", obs(), e);
        end
        step(); step();
        n_checks++;
        if (hz.StallCycles !== '0 || hz.MulDivBusy !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: got sc=%0d busy=%b want sc=0 busy=0",
                               hz.StallCycles, hz.MulDivBusy);
        end
        idle();
        @(negedge Clk);
        #1 Rst_n = 1'b1;
        step();
    endtask

    task automatic test_load_use();
        logic [4:0] e;
        idle();
        hz.MemRead_EX = 1; hz.RegWrite_EX = 1; hz.RDReg_EX = 8; hz.RSReg_ID = 8;
        @(negedge Clk);
        e = ev(1, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL lu_stall: got %b want %b", obs(), e); end
        step();
        idle(); hz.RSReg_ID = 8; hz.MemRead_M = 1; hz.RDReg_M = 8;
        @(negedge Clk);
        e = ev(0, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL lu_release: got %b want %b", obs(), e); end
        step();
        idle(); hz.MemRead_EX = 1; hz.RDReg_EX = 0; hz.RSReg_ID = 0; hz.RTReg_ID = 0; hz.UsesRT_ID = 1;
        @(negedge Clk);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL lu_r0: got %b want %b", obs(), e); end
        step();
        idle(); hz.MemRead_EX = 1; hz.RDReg_EX = 5; hz.RTReg_ID = 5; hz.UsesRT_ID = 0;
        @(negedge Clk);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL lu_rt_unused: got %b want %b", obs(), e); end
        step();
    endtask

    task automatic test_branch();
        logic [4:0] e;
        idle();
        hz.Branch_ID = 1; hz.BranchTaken_ID = 1; hz.UsesRT_ID = 1;
        hz.RSReg_ID = 3; hz.RTReg_ID = 9;
        hz.MemRead_EX = 1; hz.RegWrite_EX = 1; hz.RDReg_EX = 9;
        @(negedge Clk);
        e = ev(1, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL br_load_c1: got %b want %b", obs(), e); end
        step();
        hz.MemRead_EX = 0; hz.RegWrite_EX = 0; hz.RDReg_EX = 0;
        hz.MemRead_M = 1; hz.RDReg_M = 9;
        @(negedge Clk);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL br_load_c2: got %b want %b", obs(), e); end
        step();
        hz.MemRead_M = 0; hz.RDReg_M = 0;
        @(negedge Clk);
        e = ev(0, 1, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL br_load_flush: got %b want %b", obs(), e); end
        step();
        hz.RegWrite_EX = 1; hz.RDReg_EX = 9;
        @(negedge Clk);
        e = ev(1, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL br_alu_stall: got %b want %b", obs(), e); end
        step();
        hz.RegWrite_EX = 0; hz.RDReg_EX = 0; hz.RDReg_M = 9;
        @(negedge Clk);
        e = ev(0, 1, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL br_alu_go: got %b want %b", obs(), e); end
        step();
        idle(); hz.Jr_ID = 1; hz.RSReg_ID = 4; hz.RTReg_ID = 6;
        hz.RegWrite_EX = 1; hz.RDReg_EX = 6;
        @(negedge Clk);
        e = ev(0, 1, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL jr_rt_ignored: got %b want %b", obs(), e); end
        step();
        idle();
    endtask

    task automatic test_muldiv();
        logic [4:0] e;
        idle();
        hz.MulDivStart_ID = 1;
        @(negedge Clk);
        e = ev(0, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL md_start: got %b want %b", obs(), e); end
        step();
        hz.MulDivStart_ID = 0; hz.MulDivUse_ID = 1;
        for (int i = 1; i <= N; i++) begin
            @(negedge Clk);
            e = ev(1, 0, 1);
            n_checks++;
            if (obs() !== e) begin n_fail++; $display("FAIL md_busy_c%0d: got %b want %b", i, obs(), e); end
            step();
        end
        @(negedge Clk);
        e = ev(0, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL md_done: got %b want %b", obs(), e); end
        step();
        idle();
    endtask

    task automatic test_back_to_back();
        logic [4:0] e;
        idle();
        hz.MulDivStart_ID = 1;
        step();
        for (int i = 1; i <= N; i++) begin
            @(negedge Clk);
            e = ev(1, 0, 1);
            n_checks++;
            if (obs() !== e) begin n_fail++; $display("FAIL b2b_hold_c%0d: got %b want %b", i, obs(), e); end
            step();
        end
        @(negedge Clk);
        e = ev(0, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL b2b_accept: got %b want %b", obs(), e); end
        step();
        hz.MulDivStart_ID = 0;
        for (int i = 1; i <= N; i++) begin
            @(negedge Clk);
            e = ev(0, 0, 1);
            n_checks++;
            if (obs() !== e) begin n_fail++; $display("FAIL b2b_reload_c%0d: got %b want %b", i, obs(), e); end
            step();
        end
        @(negedge Clk);
        e = ev(0, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL b2b_idle: got %b want %b", obs(), e); end
        step();
    endtask

    task automatic test_reset_mid();
        logic [4:0] e;
        idle();
        hz.MulDivStart_ID = 1;
        step();
        hz.MulDivStart_ID = 0;
        step(); step();
        hz.MulDivUse_ID = 1; hz.Jump_ID = 1;
        hz.MemRead_EX = 1; hz.RDReg_EX = 7; hz.RSReg_ID = 7;
        #1;
        e = ev(1, 0, 1);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL rstmid_pre: got %b want %b", obs(), e); end
        Rst_n = 1'b0;
        #1;
        e = ev(0, 0, 0);
        n_checks++;
        if (obs() !== e) begin n_fail++; $display("FAIL rstmid_async: got %b want %b", obs(), e); end
        @(negedge Clk);
        #1 Rst_n = 1'b1;
        idle();
        step();
        @(negedge Clk);
        n_checks++;
        if (obs() !== e || hz.StallCycles !== '0) begin
            n_fail++; $display("FAIL rstmid_after: got %b sc=%0d want %b sc=0", obs(), hz.StallCycles, e);
        end
        step();
    endtask

    task automatic test_stats();
        int exp_sc;
        idle();
        Rst_n = 1'b0;
        #2 Rst_n = 1'b1;
        step();
        hz.MemRead_EX = 1; hz.RDReg_EX = 8; hz.RSReg_ID = 8;
        for (int i = 0; i < 20; i++) step();
`ifdef HAZARD_STATS_EN
        exp_sc = SMAX;
`else
        exp_sc = 0;
`endif
        @(negedge Clk);
        n_checks++;
        if (int'(hz.StallCycles) !== exp_sc) begin
            n_fail++; $display("FAIL stats_sat: got %0d want %0d", hz.StallCycles, exp_sc);
        end
        step(); step();
        @(negedge Clk);
        n_checks++;
        if (int'(hz.StallCycles) !== exp_sc) begin
            n_fail++; $display("FAIL stats_hold: got %0d want %0d", hz.StallCycles, exp_sc);
        end
        idle();
        step();
    endtask

    task automatic test_random();
        logic [4:0] e;
        int exp_sc;
        bit s;
        for (int i = 0; i < 400; i++) begin
            hz.RSReg_ID       = 5'($urandom_range(0, 3));
            hz.RTReg_ID       = 5'($urandom_range(0, 3));
            hz.RDReg_EX       = 5'($urandom_range(0, 3));
            hz.RDReg_M        = 5'($urandom_range(0, 3));
            hz.UsesRT_ID      = 1'($urandom_range(0, 1));
            hz.Branch_ID      = ($urandom_range(0, 3) == 0);
            hz.Jr_ID          = ($urandom_range(0, 5) == 0);
            hz.Jump_ID        = ($urandom_range(0, 7) == 0);
            hz.BranchTaken_ID = hz.Branch_ID && ($urandom_range(0, 1) == 1);
            hz.MulDivStart_ID = ($urandom_range(0, 5) == 0);
            hz.MulDivUse_ID   = ($urandom_range(0, 3) == 0);
            hz.RegWrite_EX    = 1'($urandom_range(0, 1));
            hz.MemRead_EX     = ($urandom_range(0, 2) == 0);
            hz.MemRead_M      = ($urandom_range(0, 2) == 0);
            @(negedge Clk);
            s = model_stall();
            e = ev(s, !s && (hz.BranchTaken_ID || hz.Jump_ID || hz.Jr_ID), model_busy());
`ifdef HAZARD_STATS_EN
            exp_sc = stat_m;
`else
            exp_sc = 0;
`endif
            n_checks++;
            if (obs() !== e) begin n_fail++; $display("FAIL rand_ctrl[%0d]: got %b want %b", i, obs(), e); end
            n_checks++;
            if (int'(hz.StallCycles) !== exp_sc) begin
                n_fail++; $display("FAIL rand_stats[%0d]: got %0d want %0d", i, hz.StallCycles, exp_sc);
            end
            step();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_muldiv();
        test_back_to_back();
        test_reset_mid();
        test_stats();
        Rst_n = 1'b0;
        #2 Rst_n = 1'b1;
        step();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard sequencer for the five-stage MIPS core. Decides each cycle whether the IF/ID stages stall, whether a bubble is injected into ID/EX, and whether IF/ID is flushed after a control transfer. Tracks the multi-cycle multiply/divide unit with an internal countdown so HI/LO consumers wait. Works alongside the forwarding unit and covers the hazards forwarding cannot resolve: load-use, branch-in-ID operand dependence, and mul/div occupancy.

## Interface
- MULDIV_CYCLES, 32: cycles the mul/div unit stays busy after a start is accepted; legal range 2..255.
- STAT_W, 16: width of the stall statistics counter.

- Clk  in  1  pipeline clock, rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- RSReg_ID, RTReg_ID  in  5 each  source registers of the instruction in ID.
- UsesRT_ID  in  1  ID instruction reads RT as an operand.
- Branch_ID, Jr_ID, Jump_ID  in  1 each  ID instruction is a conditional branch (reads RS and RT), a jr (reads RS), or a j/jal.
- BranchTaken_ID  in  1  branch comparator in ID resolved taken.
- MulDivStart_ID, MulDivUse_ID  in  1 each  ID instruction starts a mult/div, or reads HI/LO.
- RDReg_EX  in  5  destination register in EX.
- RegWrite_EX, MemRead_EX  in  1 each  EX instruction writes a register, or is a load.
- RDReg_M  in  5  destination register in MEM.
- MemRead_M  in  1  MEM instruction is a load.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register write enable.
- IDEXBubble  out  1  zero the ID/EX control bits this cycle.
- IFIDFlush  out  1  clear IF/ID at the next edge.
- MulDivBusy  out  1  mul/div countdown non-zero.
- StallCycles  out  STAT_W  saturating count of stalled cycles.

## Operation
- A register match counts only if the register is non-zero.
- lu = MemRead_EX and RDReg_EX matches RSReg_ID, or matches RTReg_ID with UsesRT_ID set.
- br_ex = (Branch_ID or Jr_ID), RegWrite_EX, and RDReg_EX matches RS. For Branch_ID only, a match on RT also counts.
- br_m = the same as br_ex, using MemRead_M and RDReg_M.
- md = MulDivBusy and (MulDivUse_ID or MulDivStart_ID).
- stall = lu or br_ex or br_m or md.
- PCWrite = IFIDWrite = ~stall. IDEXBubble = stall.
- IFIDFlush = ~stall and (BranchTaken_ID or Jump_ID or Jr_ID). A stalled branch never flushes.
- Count register, width $clog2(MULDIV_CYCLES+1):
  - Loads MULDIV_CYCLES when MulDivStart_ID and ~stall.
  - Otherwise decrements while non-zero.
  - A start while busy is stalled by md, so reload during a countdown is impossible.
- MulDivBusy = (Count != 0), driven from the register.

## Timing
- All stall, bubble and flush outputs are combinational, valid in the same cycle as their inputs.
- Load followed by a dependent ALU instruction: 1 stall cycle.
- Branch or jr depending on an ALU result in EX: 1 stall cycle.
- Branch or jr depending on a load in EX: 2 stall cycles (br_ex, then br_m).
- Mul/div start accepted at edge t: MulDivBusy is high for exactly MULDIV_CYCLES cycles after t. The first HI/LO reader may leave ID in the cycle busy drops.
- Simultaneous hazards: stall is the OR of all conditions; no priority is needed.
- Reset (asynchronous, any cycle, including mid-countdown):
  - Count = 0, StallCycles = 0, MulDivBusy = 0.
  - While Rst_n is low: PCWrite = 1, IFIDWrite = 1, IDEXBubble = 0, IFIDFlush = 0. All hazard terms are masked during reset.

## Configuration
- HAZARD_STATS_EN defined: StallCycles increments at each rising edge where stall = 1. It holds at all-ones (no wrap) and clears only on reset.
- HAZARD_STATS_EN undefined: the counter is not built and StallCycles is driven constant 0.

## Test plan
- Load-use: lw $8 in EX (MemRead_EX=1, RDReg_EX=8); add reading RS=8 in ID -> one cycle with PCWrite=0 and IDEXBubble=1, then PCWrite=1. Same with RDReg_EX=0 -> no stall.
- Branch after load: beq RT=9 in ID, lw $9 in EX -> stall 2 consecutive cycles, then IFIDFlush=1 if BranchTaken_ID=1. Branch after add $9 -> 1 stall cycle.
- Mul/div: MULDIV_CYCLES=4; start accepted at cycle 0 -> MulDivBusy high cycles 1-4. mflo in ID at cycle 1 -> stalled cycles 1-4, proceeds at cycle 5.
- Back-to-back mult: second MulDivStart_ID arrives while busy -> stalled until Count=0, then reloads to 4.
- Reset mid-countdown: Rst_n low at Count=2 -> MulDivBusy=0 and PCWrite=1 immediately, without waiting for a clock edge.
- Stats (HAZARD_STATS_EN): STAT_W=4, hold stall for 20 cycles -> StallCycles=15 and stays there. Without the macro -> 0.
